// File: rtl/dds_sweep_controller.sv
// Stepped linear frequency sweep sequencer that feeds the DDS phase-increment stream.
// Build option: define DDS_SWEEP_LOOP_EN to repeat the sweep until stop instead of running it once.
module dds_sweep_controller #(
   parameter int PHASE_BITS = 24,
   parameter int CHANNELS   = 8,
   parameter int COUNT_BITS = 16,
   parameter int DWELL_BITS = 16,
   localparam int CFG_BITS  = CHANNELS*2*PHASE_BITS + COUNT_BITS + DWELL_BITS,
   localparam int OUT_BITS  = CHANNELS*PHASE_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  config_in_valid,
   output logic                  config_in_ready,
   input  logic [CFG_BITS-1:0]   config_in_data,
   input  logic                  config_in_last,
   input  logic                  trigger,
   input  logic                  stop,
   output logic                  phase_inc_out_valid,
   input  logic                  phase_inc_out_ready,
   output logic [OUT_BITS-1:0]   phase_inc_out_data,
   output logic                  phase_inc_out_last,
   output logic                  busy,
   output logic                  done,
   output logic [COUNT_BITS-1:0] step_index
);

   // state | meaning
   // IDLE  | accepting configuration, waiting for trigger
   // SEND  | presenting current increments until the DDS accepts them
   // DWELL | holding off for the programmed dwell before the next step
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND  = 2'd1;
   localparam logic [1:0] S_DWELL = 2'd2;

`ifdef DDS_SWEEP_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   logic [1:0]            state;
   logic                  config_loaded;
   logic                  stop_pending;
   logic                  wrap_pending;
   logic [PHASE_BITS-1:0] start_r   [CHANNELS];
   logic [PHASE_BITS-1:0] step_r    [CHANNELS];
   logic [PHASE_BITS-1:0] current   [CHANNELS];
   logic [PHASE_BITS-1:0] next_cur  [CHANNELS];
   logic [PHASE_BITS-1:0] cfg_start [CHANNELS];
   logic [PHASE_BITS-1:0] cfg_step  [CHANNELS];
   logic [COUNT_BITS-1:0] cfg_num_steps;
   logic [DWELL_BITS-1:0] cfg_dwell;
   logic [COUNT_BITS-1:0] num_steps_r;
   logic [DWELL_BITS-1:0] dwell_r;
   logic [DWELL_BITS-1:0] dwell_cnt;
   logic [COUNT_BITS-1:0] last_idx;
   logic                  is_last;
   logic                  reload;
   logic                  cfg_hs;
   logic                  stop_req;
   logic                  unused_cfg_last;

   assign unused_cfg_last = config_in_last;

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         cfg_start[c] = config_in_data[c*PHASE_BITS +: PHASE_BITS];
         cfg_step[c]  = config_in_data[CHANNELS*PHASE_BITS + c*PHASE_BITS +: PHASE_BITS];
      end
      cfg_num_steps = config_in_data[2*CHANNELS*PHASE_BITS +: COUNT_BITS];
      cfg_dwell     = config_in_data[2*CHANNELS*PHASE_BITS + COUNT_BITS +: DWELL_BITS];
   end

   // A zero step count still produces one word.
   assign last_idx = (num_steps_r == '0) ? '0 : num_steps_r - 1'b1;
   assign is_last  = (step_index == last_idx);
   assign reload   = (state == S_DWELL) ? wrap_pending : (LOOP_EN && is_last);
   assign cfg_hs   = config_in_valid && config_in_ready;
   assign stop_req = stop || stop_pending;

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         next_cur[c] = reload ? start_r[c] : current[c] + step_r[c];
      end
   end

   always_comb begin
      phase_inc_out_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         phase_inc_out_data[c*PHASE_BITS +: PHASE_BITS] = current[c];
      end
   end

   assign config_in_ready     = !reset && (state == S_IDLE);
   assign phase_inc_out_valid = (state == S_SEND);
   assign phase_inc_out_last  = (state == S_SEND) && is_last;
   assign busy                = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         config_loaded <= 1'b0;
         stop_pending  <= 1'b0;
         wrap_pending  <= 1'b0;
         num_steps_r   <= '0;
         dwell_r       <= '0;
         dwell_cnt     <= '0;
         step_index    <= '0;
         done          <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            start_r[c] <= '0;
            step_r[c]  <= '0;
            current[c] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               stop_pending <= 1'b0;
               wrap_pending <= 1'b0;
               if (cfg_hs) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     start_r[c] <= cfg_start[c];
                     step_r[c]  <= cfg_step[c];
                  end
                  num_steps_r   <= cfg_num_steps;
                  dwell_r       <= cfg_dwell;
                  config_loaded <= 1'b1;
               end
               // Trigger beats a simultaneous stop; a same-cycle config is used directly.
               if (trigger && (config_loaded || cfg_hs)) begin
                  state      <= S_SEND;
                  step_index <= '0;
                  for (int c = 0; c < CHANNELS; c++) begin
                     current[c] <= cfg_hs ? cfg_start[c] : start_r[c];
                  end
               end
            end
            S_SEND: begin
               if (stop) stop_pending <= 1'b1;
               if (phase_inc_out_ready) begin
                  if (stop_req || (is_last && !LOOP_EN)) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end else if (dwell_r == '0) begin
                     step_index <= reload ? '0 : step_index + 1'b1;
                     for (int c = 0; c < CHANNELS; c++) current[c] <= next_cur[c];
                  end else begin
                     state        <= S_DWELL;
                     dwell_cnt    <= dwell_r - 1'b1;
                     wrap_pending <= is_last;
                  end
               end
            end
            S_DWELL: begin
               if (stop) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end else if (dwell_cnt == '0) begin
                  state      <= S_SEND;
                  step_index <= reload ? '0 : step_index + 1'b1;
                  for (int c = 0; c < CHANNELS; c++) current[c] <= next_cur[c];
               end else begin
                  dwell_cnt <= dwell_cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Randomized self-checking bench for dds_sweep_controller against an arithmetic sweep model.
// The loop-mode scenario is selected when DDS_SWEEP_LOOP_EN is defined.
module tb_dds_sweep_controller;
   localparam int PB = 24, CH = 2, CB = 16, DB = 16;
   localparam int CW = CH*2*PB + CB + DB;
   localparam int OW = CH*PB;

   logic clk = 0, reset = 1, cfg_valid = 0, cfg_ready, cfg_last = 0;
   logic trigger = 0, stop = 0, out_valid, out_ready = 1, out_last, busy, done;
   logic [CW-1:0] cfg_data = '0;
   logic [OW-1:0] out_data;
   logic [CB-1:0] step_index;

   int cyc = 0, n_tests = 0, n_fail = 0;

   logic [OW-1:0] hs_data[$];
   bit            hs_last[$];
   int            hs_cyc[$], pres_cyc[$], done_cyc[$];
   int            stab_err = 0;
   bit            prev_pend = 0;
   logic [OW-1:0] prev_data = '0;
   logic          prev_lastb = 0;

   int bp_word = -1, bp_len = 0, bp_cnt = 0, stop_word = -1, stop_mode = 0, stop_cyc = -1, trig_cyc = 0;
   bit rand_rdy = 0, stop_fired = 0;

   dds_sweep_controller #(.PHASE_BITS(PB), .CHANNELS(CH), .COUNT_BITS(CB), .DWELL_BITS(DB)) dut (
      .clk(clk), .reset(reset),
      .config_in_valid(cfg_valid), .config_in_ready(cfg_ready),
      .config_in_data(cfg_data), .config_in_last(cfg_last),
      .trigger(trigger), .stop(stop),
      .phase_inc_out_valid(out_valid), .phase_inc_out_ready(out_ready),
      .phase_inc_out_data(out_data), .phase_inc_out_last(out_last),
      .busy(busy), .done(done), .step_index(step_index));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stream monitor: records presentations, handshakes, done pulses and any drop of an unaccepted word.
   always @(negedge clk) begin
      if (reset) begin
         prev_pend <= 0;
      end else begin
         if (prev_pend && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_lastb))
            stab_err <= stab_err + 1;
         if (out_valid === 1'b1 && !prev_pend) pres_cyc.push_back(cyc);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_data.push_back(out_data);
            hs_last.push_back(out_last);
            hs_cyc.push_back(cyc);
         end
         if (done === 1'b1) done_cyc.push_back(cyc);
         prev_pend  <= out_valid && !out_ready;
         prev_data  <= out_data;
         prev_lastb <= out_last;
      end
   end

   function automatic logic [OW-1:0] model_word(input logic [OW-1:0] st, input logic [OW-1:0] sp, input int k);
      logic [63:0] a0, a1;
      a0 = 64'(st[23:0])  + 64'(k) * 64'(sp[23:0]);
      a1 = 64'(st[47:24]) + 64'(k) * 64'(sp[47:24]);
      return {a1[23:0], a0[23:0]};
   endfunction

   function automatic logic [CW-1:0] pack_cfg(input logic [OW-1:0] st, input logic [OW-1:0] sp,
                                               input logic [CB-1:0] n, input logic [DB-1:0] dw);
      return {dw, n, sp, st};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_mon();
      hs_data.delete(); hs_last.delete(); hs_cyc.delete(); pres_cyc.delete(); done_cyc.delete();
      bp_word = -1; bp_len = 0; bp_cnt = 0; stop_word = -1; stop_mode = 0;
      stop_fired = 0; stop_cyc = -1; rand_rdy = 0; out_ready = 1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         trigger = 0;
         stop = 0;
         if (out_valid && hs_data.size() == bp_word && bp_cnt < bp_len) begin
            out_ready = 0;
            bp_cnt++;
         end else begin
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (stop_word >= 0 && !stop_fired) begin
            if ((stop_mode == 0 && busy && !out_valid && hs_data.size() == stop_word + 1) ||
                (stop_mode == 1 && out_valid && !out_ready && hs_data.size() == stop_word)) begin
               stop = 1;
               stop_fired = 1;
               stop_cyc = cyc;
            end
         end
      end
   endtask

   task automatic load_cfg(input logic [CW-1:0] d, output int acc);
      tick();
      cfg_valid = 1;
      cfg_data = d;
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cfg_ready === 1'b1) begin
            acc = cyc;
            break;
         end
      end
      tick();
      cfg_valid = 0;
   endtask

   task automatic start_sweep();
      tick();
      trigger = 1;
      trig_cyc = cyc;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) tick();
      n_tests++; if ({out_valid, out_last, busy, done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, out_last, busy, done}); end
      n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_data); end
      n_tests++; if (step_index !== '0) begin n_fail++; $display("FAIL reset_step_index: got %0d expected 0", step_index); end
      n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 0", cfg_ready); end
      reset = 0;
      #1;
      n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cfg_ready: got %b expected 1", cfg_ready); end
   endtask

   task automatic test_no_config();
      clear_mon();
      start_sweep();
      run(10);
      n_tests++; if (hs_data.size() != 0) begin n_fail++; $display("FAIL noconfig_words: got %0d expected 0", hs_data.size()); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noconfig_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      int acc, se0, nw;
      logic [OW-1:0] st, sp;
      clear_mon(); se0 = stab_err;
      st = {24'h001000, 24'h000100}; sp = {24'h000020, 24'h000010};
      load_cfg(pack_cfg(st, sp, 16'd4, 16'd3), acc);
      n_tests++; if (acc < 0) begin n_fail++; $display("FAIL basic_cfg_accept: got timeout expected handshake"); end
      start_sweep();
      run(30);
      nw = hs_data.size();
      n_tests++; if (nw != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", nw); end
      for (int k = 0; k < nw; k++) begin
         n_tests++; if (hs_data[k] !== model_word(st, sp, k)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0h expected %0h", k, hs_data[k], model_word(st, sp, k)); end
         n_tests++; if (hs_last[k] !== (k == 3)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b expected %b", k, hs_last[k], k == 3); end
         n_tests++; if (pres_cyc[k] != trig_cyc + 1 + 4*k) begin n_fail++; $display("FAIL basic_valid_cycle[%0d]: got %0d expected %0d", k, pres_cyc[k], trig_cyc + 1 + 4*k); end
      end
      if (nw == 4) begin
         n_tests++; if (hs_data[3] !== 48'h001060_000130) begin n_fail++; $display("FAIL basic_word4: got %0h expected 001060000130", hs_data[3]); end
      end
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc[nw-1] + 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", done_cyc.size(), done_cyc[0], hs_cyc[nw-1] + 1); end
      n_tests++; if (step_index !== 16'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_end_state: got idx %0d busy %b expected 3 0", step_index, busy); end
      n_tests++; if (stab_err != se0) begin n_fail++; $display("FAIL basic_stable: got %0d drops expected 0", stab_err - se0); end
   endtask

   task automatic test_backpressure();
      int acc, se0, nw;
      logic [OW-1:0] st, sp;
      clear_mon(); se0 = stab_err;
      st = {24'h001000, 24'h000100}; sp = {24'h000020, 24'h000010};
      load_cfg(pack_cfg(st, sp, 16'd4, 16'd3), acc);
      bp_word = 1; bp_len = 5;
      start_sweep();
      run(40);
      nw = hs_data.size();
      n_tests++; if (nw != 4 || pres_cyc.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d words %0d presentations expected 4 4", nw, pres_cyc.size()); end
      for (int k = 0; k < nw; k++) begin
         n_tests++; if (hs_data[k] !== model_word(st, sp, k)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h expected %0h", k, hs_data[k], model_word(st, sp, k)); end
         if (k > 0) begin
            n_tests++; if (pres_cyc[k] != hs_cyc[k-1] + 4) begin n_fail++; $display("FAIL bp_dwell[%0d]: got %0d expected %0d", k, pres_cyc[k], hs_cyc[k-1] + 4); end
         end
      end
      n_tests++; if (hs_cyc[1] != pres_cyc[1] + 5) begin n_fail++; $display("FAIL bp_stall_len: got %0d expected %0d", hs_cyc[1] - pres_cyc[1], 5); end
      n_tests++; if (stab_err != se0) begin n_fail++; $display("FAIL bp_stable: got %0d drops expected 0", stab_err - se0); end
   endtask

   task automatic test_wrap();
      int acc, nw;
      logic [OW-1:0] st, sp;
      clear_mon();
      st = {24'h123456, 24'hFFFFF0}; sp = {24'hFFFFFF, 24'h000020};
      load_cfg(pack_cfg(st, sp, 16'd2, 16'd0), acc);
      start_sweep();
      run(12);
      nw = hs_data.size();
      n_tests++; if (nw != 2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", nw); end
      n_tests++; if (hs_data[0] !== 48'h123456_FFFFF0) begin n_fail++; $display("FAIL wrap_word0: got %0h expected 123456fffff0", hs_data[0]); end
      n_tests++; if (hs_data[1] !== 48'h123455_000010) begin n_fail++; $display("FAIL wrap_word1: got %0h expected 123455000010", hs_data[1]); end
      n_tests++; if (hs_cyc[1] != hs_cyc[0] + 1 || hs_last[0] !== 1'b0 || hs_last[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_timing: got gap %0d last %b%b expected 1 01", hs_cyc[1] - hs_cyc[0], hs_last[0], hs_last[1]); end
      clear_mon();
      load_cfg(pack_cfg(st, sp, 16'd0, 16'd2), acc);
      start_sweep();
      run(12);
      n_tests++; if (hs_data.size() != 1 || hs_last[0] !== 1'b1) begin n_fail++; $display("FAIL zero_steps: got %0d words last %b expected 1 1", hs_data.size(), hs_last[0]); end
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc[0] + 1) begin n_fail++; $display("FAIL zero_steps_done: got %0d pulses expected 1 at %0d", done_cyc.size(), hs_cyc[0] + 1); end
   endtask

   task automatic test_abort();
      int acc, se0;
      logic [OW-1:0] st, sp;
      clear_mon();
      st = {24'h000500, 24'h000700}; sp = {24'h000003, 24'h000005};
      load_cfg(pack_cfg(st, sp, 16'd6, 16'd3), acc);
      stop_word = 1; stop_mode = 0;
      start_sweep();
      run(40);
      n_tests++; if (hs_data.size() != 2) begin n_fail++; $display("FAIL abort_dwell_words: got %0d expected 2", hs_data.size()); end
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != stop_cyc + 1) begin n_fail++; $display("FAIL abort_dwell_done: got %0d pulses at %0d expected 1 at %0d", done_cyc.size(), done_cyc[0], stop_cyc + 1); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_dwell_busy: got %b expected 0", busy); end
      clear_mon(); se0 = stab_err;
      stop_word = 1; stop_mode = 1; bp_word = 1; bp_len = 3;
      start_sweep();
      run(40);
      n_tests++; if (hs_data.size() != 2 || hs_data[1] !== model_word(st, sp, 1)) begin n_fail++; $display("FAIL abort_send_words: got %0d last %0h expected 2 %0h", hs_data.size(), hs_data[1], model_word(st, sp, 1)); end
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc[1] + 1) begin n_fail++; $display("FAIL abort_send_done: got %0d pulses at %0d expected 1 at %0d", done_cyc.size(), done_cyc[0], hs_cyc[1] + 1); end
      n_tests++; if (hs_cyc[1] != pres_cyc[1] + 3 || stab_err != se0) begin n_fail++; $display("FAIL abort_send_hold: got stall %0d drops %0d expected 3 0", hs_cyc[1] - pres_cyc[1], stab_err - se0); end
   endtask

   task automatic test_config_gating();
      int acc, acc_b;
      logic [OW-1:0] sta, spa, stb, spb;
      clear_mon();
      sta = {24'h000200, 24'h000300}; spa = {24'h000001, 24'h000002};
      stb = {24'hABCDEF, 24'h000001}; spb = {24'h000010, 24'h000010};
      load_cfg(pack_cfg(sta, spa, 16'd3, 16'd2), acc);
      start_sweep();
      fork
         load_cfg(pack_cfg(stb, spb, 16'd2, 16'd0), acc_b);
         run(40);
      join
      n_tests++; if (hs_data.size() != 3 || hs_data[2] !== model_word(sta, spa, 2)) begin n_fail++; $display("FAIL gate_old_cfg: got %0d words last %0h expected 3 %0h", hs_data.size(), hs_data[2], model_word(sta, spa, 2)); end
      n_tests++; if (done_cyc.size() != 1 || acc_b != done_cyc[0]) begin n_fail++; $display("FAIL gate_accept_cycle: got %0d expected %0d", acc_b, done_cyc[0]); end
      clear_mon();
      start_sweep();
      run(20);
      n_tests++; if (hs_data.size() != 2 || hs_data[0] !== stb || hs_data[1] !== model_word(stb, spb, 1)) begin n_fail++; $display("FAIL gate_new_cfg: got %0d words %0h %0h expected 2 %0h %0h", hs_data.size(), hs_data[0], hs_data[1], stb, model_word(stb, spb, 1)); end
      load_cfg(pack_cfg(sta, spa, 16'd3, 16'd2), acc);
      start_sweep();
      run(3);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_running: got %b expected 1", busy); end
      reset = 1;
      tick();
      n_tests++; if ({out_valid, out_last, busy, done, cfg_ready} !== 5'b0 || out_data !== '0 || step_index !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %b data %0h idx %0d expected 00000 0 0", {out_valid, out_last, busy, done, cfg_ready}, out_data, step_index); end
      reset = 0;
      clear_mon();
      start_sweep();
      run(10);
      n_tests++; if (hs_data.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_trigger: got %0d words busy %b expected 0 0", hs_data.size(), busy); end
   endtask

   task automatic test_random();
      int acc, se0, nw, eff, dw;
      logic [OW-1:0] st, sp;
      logic [CB-1:0] n;
      for (int r = 0; r < 6; r++) begin
         clear_mon(); se0 = stab_err;
         st = {24'($urandom), 24'($urandom)};
         sp = {24'($urandom), 24'($urandom)};
         n = CB'($urandom_range(0, 5));
         dw = $urandom_range(0, 4);
         eff = (n == 0) ? 1 : int'(n);
         load_cfg(pack_cfg(st, sp, n, DB'(dw)), acc);
         rand_rdy = 1;
         start_sweep();
         run(eff*(dw+1)*4 + 30);
         nw = hs_data.size();
         n_tests++; if (nw != eff) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", r, nw, eff); end
         for (int k = 0; k < nw; k++) begin
            n_tests++; if (hs_data[k] !== model_word(st, sp, k) || hs_last[k] !== (k == eff-1)) begin n_fail++; $display("FAIL rand%0d_word[%0d]: got %0h last %b expected %0h last %b", r, k, hs_data[k], hs_last[k], model_word(st, sp, k), k == eff-1); end
            if (k > 0) begin
               n_tests++; if (pres_cyc[k] != hs_cyc[k-1] + 1 + dw) begin n_fail++; $display("FAIL rand%0d_dwell[%0d]: got %0d expected %0d", r, k, pres_cyc[k], hs_cyc[k-1] + 1 + dw); end
            end
         end
         n_tests++; if (done_cyc.size() != 1 || stab_err != se0) begin n_fail++; $display("FAIL rand%0d_done: got %0d pulses %0d drops expected 1 0", r, done_cyc.size(), stab_err - se0); end
      end
   endtask

   task automatic test_loop();
      int acc, nw;
      logic [OW-1:0] st, sp;
      clear_mon();
      st = {24'h00A000, 24'hFFFFF8}; sp = {24'h000100, 24'h000004};
      load_cfg(pack_cfg(st, sp, 16'd3, 16'd1), acc);
      stop_word = 7; stop_mode = 0;
      start_sweep();
      run(40);
      nw = hs_data.size();
      n_tests++; if (nw != 8) begin n_fail++; $display("FAIL loop_count: got %0d expected 8", nw); end
      for (int k = 0; k < nw; k++) begin
         n_tests++; if (hs_data[k] !== model_word(st, sp, k % 3) || hs_last[k] !== (k % 3 == 2)) begin n_fail++; $display("FAIL loop_word[%0d]: got %0h last %b expected %0h last %b", k, hs_data[k], hs_last[k], model_word(st, sp, k % 3), k % 3 == 2); end
      end
      n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != stop_cyc + 1) begin n_fail++; $display("FAIL loop_done: got %0d pulses at %0d expected 1 at %0d", done_cyc.size(), done_cyc[0], stop_cyc + 1); end
   endtask

   initial begin
      test_reset();
      test_no_config();
`ifdef DDS_SWEEP_LOOP_EN
      test_loop();
`else
      test_basic();
      test_backpressure();
      test_wrap();
      test_abort();
      test_config_gating();
      test_random();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
